// File: rtl/ex_operand_b_select_pkg.sv
// rtl/ex_operand_b_select_pkg.sv - shared constants for the EX-stage operand B selector
package ex_operand_b_select_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic ALU_SRC_REG = 1'b0;
    localparam logic ALU_SRC_IMM = 1'b1;

endpackage

// File: rtl/ex_operand_b_select_if.sv
// rtl/ex_operand_b_select_if.sv - operand B selector signal bundle
interface ex_operand_b_select_if
    import ex_operand_b_select_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] EX_rd2;
    logic [WIDTH-1:0] EX_imm;
    logic             EX_alu_src;
    logic [1:0]       EX_fwd_b;
    logic [WIDTH-1:0] MEM_alu_out;
    logic [WIDTH-1:0] WB_wr_data;
    logic             EX_stall;
    logic [WIDTH-1:0] EX_alu_in2;
    logic [WIDTH-1:0] EX_store_data;
    logic [WIDTH-1:0] EX_alu_in2_q;

    // pipeline side: drives ID/EX, forwarding sources and stall, observes the results
    modport master (
        output EX_rd2, EX_imm, EX_alu_src, EX_fwd_b, MEM_alu_out, WB_wr_data, EX_stall,
        input  EX_alu_in2, EX_store_data, EX_alu_in2_q
    );

    // selector side
    modport slave (
        input  EX_rd2, EX_imm, EX_alu_src, EX_fwd_b, MEM_alu_out, WB_wr_data, EX_stall,
        output EX_alu_in2, EX_store_data, EX_alu_in2_q
    );
endinterface

// File: rtl/ex_operand_b_select_mux2_w.sv
// rtl/ex_operand_b_select_mux2_w.sv - parameterised WIDTH-bit 2:1 mux
module mux2_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // sel=1 picks b, anything else falls back to a
    always_comb begin
        y = a;
        if (sel) begin
            y = b;
        end
    end

endmodule

// File: rtl/ex_operand_b_select.sv
// rtl/ex_operand_b_select.sv - EX-stage ALU operand B forwarding/immediate select
module ex_operand_b_select
    import ex_operand_b_select_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_operand_b_select_if.slave  bus
);

    logic             sel_wb;
    logic             sel_mem;
    logic             sel_imm;
    logic [WIDTH-1:0] rd2_or_wb;
    logic [WIDTH-1:0] fwd_rt;
    logic [WIDTH-1:0] alu_in2;
    logic [WIDTH-1:0] alu_in2_q;

    // The illegal code 2'b11 matches neither select, so it falls through to rd2.
    assign sel_wb  = (bus.EX_fwd_b == FWD_WB);
    assign sel_mem = (bus.EX_fwd_b == FWD_MEM);
    assign sel_imm = (bus.EX_alu_src == ALU_SRC_IMM);

    mux2_w #(.WIDTH(WIDTH)) u_fwd_wb (
        .a   (bus.EX_rd2),
        .b   (bus.WB_wr_data),
        .sel (sel_wb),
        .y   (rd2_or_wb)
    );

    mux2_w #(.WIDTH(WIDTH)) u_fwd_mem (
        .a   (rd2_or_wb),
        .b   (bus.MEM_alu_out),
        .sel (sel_mem),
        .y   (fwd_rt)
    );

    mux2_w #(.WIDTH(WIDTH)) u_src (
        .a   (fwd_rt),
        .b   (bus.EX_imm),
        .sel (sel_imm),
        .y   (alu_in2)
    );

    // trace copy of operand B; reset wins over stall
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_in2_q <= '0;
        end else if (!bus.EX_stall) begin
            alu_in2_q <= alu_in2;
        end
    end

    assign bus.EX_alu_in2    = alu_in2;
    assign bus.EX_store_data = fwd_rt;
    assign bus.EX_alu_in2_q  = alu_in2_q;

endmodule

// File: tb/tb_ex_operand_b_select.sv
// tb/tb_ex_operand_b_select.sv - scoreboard bench for ex_operand_b_select
module tb_ex_operand_b_select;

    localparam int W = 32;
    localparam int K_ALU = 0;
    localparam int K_STORE = 1;
    localparam int K_Q = 2;

    logic clk;
    logic rst;

    ex_operand_b_select_if #(.WIDTH(W)) bus ();

    ex_operand_b_select #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          exp_kind[$];
    logic [W-1:0] exp_val[$];
    string       exp_tag[$];
    int          compared;
    int          mismatched;
    event        sample_ev;

    task automatic expect_out(input int kind, input logic [W-1:0] val, input string tag);
        exp_kind.push_back(kind);
        exp_val.push_back(val);
        exp_tag.push_back(tag);
    endtask

    task automatic present();
        -> sample_ev;
        #2;
    endtask

    task automatic drive(input logic [W-1:0] rd2, input logic [W-1:0] imm, input logic src,
                         input logic [1:0] fwd, input logic [W-1:0] mem, input logic [W-1:0] wb);
        bus.EX_rd2      = rd2;
        bus.EX_imm      = imm;
        bus.EX_alu_src  = src;
        bus.EX_fwd_b    = fwd;
        bus.MEM_alu_out = mem;
        bus.WB_wr_data  = wb;
    endtask

    // monitor: samples 1 time unit after each presentation and drains the scoreboard
    initial begin
        compared = 0;
        mismatched = 0;
        forever begin
            @(sample_ev);
            #1;
            while (exp_kind.size() > 0) begin
                int          k;
                logic [W-1:0] e;
                logic [W-1:0] a;
                string       t;
                k = exp_kind.pop_front();
                e = exp_val.pop_front();
                t = exp_tag.pop_front();
                case (k)
                    K_ALU:   a = bus.EX_alu_in2;
                    K_STORE: a = bus.EX_store_data;
                    default: a = bus.EX_alu_in2_q;
                endcase
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL %s: got %h expected %h", t, a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.EX_stall = 1'b0;
        drive('0, '0, 1'b0, 2'b00, '0, '0);

        // reset state
        @(negedge clk);
        expect_out(K_ALU,   32'h0, "reset_alu_in2");
        expect_out(K_STORE, 32'h0, "reset_store");
        expect_out(K_Q,     32'h0, "reset_q");
        present();
        rst = 1'b0;

        // register path
        @(negedge clk);
        drive(32'h0000000F, 32'h0000001F, 1'b0, 2'b00, '0, '0);
        expect_out(K_ALU,   32'h0000000F, "reg_alu_in2");
        expect_out(K_STORE, 32'h0000000F, "reg_store");
        present();
        bus.EX_alu_src = 1'b1;
        expect_out(K_ALU,   32'h0000001F, "imm_alu_in2");
        expect_out(K_STORE, 32'h0000000F, "imm_store");
        present();

        // forwarding
        drive(32'h11, 32'h0, 1'b0, 2'b10, 32'h22, 32'h33);
        expect_out(K_ALU,   32'h22, "fwd_mem_alu");
        expect_out(K_STORE, 32'h22, "fwd_mem_store");
        present();
        bus.EX_fwd_b = 2'b01;
        expect_out(K_ALU,   32'h33, "fwd_wb_alu");
        expect_out(K_STORE, 32'h33, "fwd_wb_store");
        present();
        bus.EX_fwd_b = 2'b11;
        expect_out(K_ALU,   32'h11, "fwd_illegal_alu");
        present();
        bus.EX_fwd_b = 2'b00;
        expect_out(K_ALU,   32'h11, "fwd_none_alu");
        present();
        bus.EX_alu_src = 1'b1;
        bus.EX_imm = 32'hFFFF8000;
        expect_out(K_ALU,   32'hFFFF8000, "fwd_imm_alu");
        expect_out(K_STORE, 32'h11, "fwd_imm_store");
        present();
        bus.EX_fwd_b = 2'b10;
        expect_out(K_ALU,   32'hFFFF8000, "fwd_mem_imm_alu");
        expect_out(K_STORE, 32'h22, "fwd_mem_imm_store");
        present();

        // full-width pass-through
        drive(32'hFFFFFFFF, 32'h80000001, 1'b0, 2'b00, '0, '0);
        for (int i = 0; i < 4; i++) begin
            bus.EX_alu_src = i[0];
            expect_out(K_ALU, i[0] ? 32'h80000001 : 32'hFFFFFFFF, "width_alu");
            expect_out(K_STORE, 32'hFFFFFFFF, "width_store");
            present();
        end

        // reset while operand B is 0x1F
        drive(32'h0000000F, 32'h0000001F, 1'b1, 2'b00, '0, '0);
        @(negedge clk);
        expect_out(K_Q, 32'h1F, "q_load");
        present();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_out(K_Q,   32'h0,  "rst_q");
        expect_out(K_ALU, 32'h1F, "rst_alu_follows");
        present();
        rst = 1'b0;
        @(negedge clk);
        expect_out(K_Q, 32'h1F, "rst_release_q");
        present();

        // stall
        bus.EX_stall = 1'b1;
        bus.EX_alu_src = 1'b0;
        expect_out(K_ALU, 32'h0F, "stall_alu");
        present();
        @(negedge clk);
        expect_out(K_Q, 32'h1F, "stall_q_hold");
        present();
        bus.EX_stall = 1'b0;
        @(negedge clk);
        expect_out(K_Q, 32'h0F, "unstall_q");
        present();

        // reset during stall
        bus.EX_alu_src = 1'b1;
        @(negedge clk);
        expect_out(K_Q, 32'h1F, "pre_rst_stall_q");
        present();
        bus.EX_stall = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        expect_out(K_Q, 32'h0, "rst_stall_q");
        present();
        rst = 1'b0;
        @(negedge clk);
        expect_out(K_Q, 32'h0, "stall_after_rst_q");
        present();
        bus.EX_stall = 1'b0;
        @(negedge clk);
        expect_out(K_Q, 32'h1F, "resume_q");
        present();

        #5;
        if (exp_kind.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_kind.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
